// File: rtl/parity_stream_arbiter.sv
// parity_stream_arbiter: packet-level round-robin merge of the even- and odd-parity
// AXI-Stream sources onto one link. tuser tags the source of each beat (0=even, 1=odd).
// A beat-count watchdog forces tlast after MAX_BEATS beats and drains the remainder.
// Optional build macro PARITY_ARB_STATS_EN adds packet and drop counters.
module parity_stream_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic              a_clk,
  input  logic              axis_aresetn,
  input  logic              axis_s_tvalid_even,
  output logic              axis_s_tready_even,
  input  logic [DATA_W-1:0] axis_s_tdata_even,
  input  logic              axis_s_tlast_even,
  input  logic              axis_s_tvalid_odd,
  output logic              axis_s_tready_odd,
  input  logic [DATA_W-1:0] axis_s_tdata_odd,
  input  logic              axis_s_tlast_odd,
  output logic              axis_m_tvalid,
  input  logic              axis_m_tready,
  output logic [DATA_W-1:0] axis_m_tdata,
  output logic              axis_m_tlast,
  output logic              axis_m_tuser,
  input  logic              err_clr,
  output logic              err_overflow,
`ifdef PARITY_ARB_STATS_EN
  output logic [15:0]       pkt_cnt_even,
  output logic [15:0]       pkt_cnt_odd,
  output logic [15:0]       drop_cnt,
`endif
  output logic              busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W:0] MAX_B = (CNT_W+1)'(MAX_BEATS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT_EVEN,
    ST_GRANT_ODD,
    ST_DRAIN_EVEN,
    ST_DRAIN_ODD
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;   // 0=even, 1=odd
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_last_q, m_last_d;
  logic                m_user_q, m_user_d;
  logic                err_q, err_d;

  logic                load_ok_c;
  logic                sel_odd_c;
  logic                sel_valid_c;
  logic                sel_last_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic                rdy_even_c;
  logic                rdy_odd_c;
  logic [CNT_W:0]      beat_nxt_c;

  // Source mux: the input the current grant or drain state is listening to
  always_comb begin
    sel_odd_c   = (state_q == ST_GRANT_ODD) || (state_q == ST_DRAIN_ODD);
    sel_valid_c = sel_odd_c ? axis_s_tvalid_odd : axis_s_tvalid_even;
    sel_last_c  = sel_odd_c ? axis_s_tlast_odd  : axis_s_tlast_even;
    sel_data_c  = sel_odd_c ? axis_s_tdata_odd  : axis_s_tdata_even;
  end

  // Arbitration, input handshake, watchdog and output register next values
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    m_user_d     = m_user_q;
    err_d        = err_q;
    rdy_even_c   = 1'b0;
    rdy_odd_c    = 1'b0;
    load_ok_c    = !m_valid_q || axis_m_tready;
    beat_nxt_c   = {1'b0, beat_cnt_q} + (CNT_W+1)'(1);

    // Output beat consumed downstream; a new load below overrides this
    if (m_valid_q && axis_m_tready) m_valid_d = 1'b0;
    // Clear first so a same-cycle overflow below wins
    if (err_clr) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (axis_s_tvalid_even && (!axis_s_tvalid_odd || last_grant_q)) begin
          state_d      = ST_GRANT_EVEN;
          last_grant_d = 1'b0;
        end else if (axis_s_tvalid_odd) begin
          state_d      = ST_GRANT_ODD;
          last_grant_d = 1'b1;
        end
      end
      ST_GRANT_EVEN, ST_GRANT_ODD: begin
        rdy_even_c = !sel_odd_c && load_ok_c;
        rdy_odd_c  = sel_odd_c && load_ok_c;
        if (sel_valid_c && load_ok_c) begin
          m_valid_d = 1'b1;
          m_data_d  = sel_data_c;
          m_user_d  = sel_odd_c;
          if (sel_last_c) begin
            m_last_d   = 1'b1;
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end else if (beat_nxt_c == MAX_B) begin
            // Packet too long: terminate it here and swallow the rest
            m_last_d   = 1'b1;
            err_d      = 1'b1;
            beat_cnt_d = '0;
            state_d    = sel_odd_c ? ST_DRAIN_ODD : ST_DRAIN_EVEN;
          end else begin
            m_last_d   = 1'b0;
            beat_cnt_d = beat_nxt_c[CNT_W-1:0];
          end
        end
      end
      ST_DRAIN_EVEN, ST_DRAIN_ODD: begin
        rdy_even_c = !sel_odd_c;
        rdy_odd_c  = sel_odd_c;
        if (sel_valid_c && sel_last_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; last_grant resets to odd so even wins the first tie
  always_ff @(posedge a_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      m_user_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      m_user_q     <= m_user_d;
      err_q        <= err_d;
    end
  end

  assign axis_s_tready_even = rdy_even_c;
  assign axis_s_tready_odd  = rdy_odd_c;
  assign axis_m_tvalid      = m_valid_q;
  assign axis_m_tdata       = m_data_q;
  assign axis_m_tlast       = m_last_q;
  assign axis_m_tuser       = m_user_q;
  assign err_overflow       = err_q;
  assign busy               = (state_q != ST_IDLE) || m_valid_q;

`ifdef PARITY_ARB_STATS_EN
  localparam int unsigned STAT_W = 16;

  logic [STAT_W-1:0] pkt_even_q, pkt_even_d;
  logic [STAT_W-1:0] pkt_odd_q, pkt_odd_d;
  logic [STAT_W-1:0] drop_q, drop_d;

  // Count delivered packets per source and beats discarded while draining
  always_comb begin
    pkt_even_d = pkt_even_q;
    pkt_odd_d  = pkt_odd_q;
    drop_d     = drop_q;
    if (m_valid_q && axis_m_tready && m_last_q) begin
      if (m_user_q) pkt_odd_d  = pkt_odd_q + STAT_W'(1);
      else          pkt_even_d = pkt_even_q + STAT_W'(1);
    end
    if (((state_q == ST_DRAIN_EVEN) && axis_s_tvalid_even) ||
        ((state_q == ST_DRAIN_ODD) && axis_s_tvalid_odd))
      drop_d = drop_q + STAT_W'(1);
  end

  // Statistics registers
  always_ff @(posedge a_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      pkt_even_q <= '0;
      pkt_odd_q  <= '0;
      drop_q     <= '0;
    end else begin
      pkt_even_q <= pkt_even_d;
      pkt_odd_q  <= pkt_odd_d;
      drop_q     <= drop_d;
    end
  end

  assign pkt_cnt_even = pkt_even_q;
  assign pkt_cnt_odd  = pkt_odd_q;
  assign drop_cnt     = drop_q;
`endif

endmodule

// File: doc/parity_stream_arbiter.md
Name: parity_stream_arbiter

Overview:
Packet-level round-robin arbiter that merges the odd- and even-parity AXI-Stream outputs of the parity filter back onto one 8-bit AXI-Stream link. Once a source is granted it holds the link until that source's tlast. An extra output bit tags each beat with its source. A beat-count watchdog caps packet length so a missing tlast cannot stall the shared link.

Parameters:
DATA_W, 8, data width of all streams
MAX_BEATS, 8, maximum beats per packet before a forced tlast (range 1..255)

Ports:
a_clk  in  1  clock, all logic on rising edge
axis_aresetn  in  1  asynchronous active-low reset
axis_s_tvalid_even  in  1  even source valid
axis_s_tready_even  out  1  even source ready
axis_s_tdata_even  in  DATA_W  even source data
axis_s_tlast_even  in  1  even source end of packet
axis_s_tvalid_odd  in  1  odd source valid
axis_s_tready_odd  out  1  odd source ready
axis_s_tdata_odd  in  DATA_W  odd source data
axis_s_tlast_odd  in  1  odd source end of packet
axis_m_tvalid  out  1  merged output valid (registered)
axis_m_tready  in  1  downstream ready
axis_m_tdata  out  DATA_W  merged data (registered)
axis_m_tlast  out  1  merged end of packet (registered)
axis_m_tuser  out  1  source tag: 0=even, 1=odd (registered)
err_clr  in  1  synchronous pulse, clears err_overflow
err_overflow  out  1  sticky flag: a packet exceeded MAX_BEATS
busy  out  1  high whenever state != IDLE or axis_m_tvalid=1

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_grant=ODD (so even wins the first tie), beat_cnt=0, axis_m_tvalid=0, tdata=0, tlast=0, tuser=0, err_overflow=0. Both s_tready=0.
- States: IDLE, GRANT_EVEN, GRANT_ODD, DRAIN_EVEN, DRAIN_ODD.
- IDLE: if only one source has tvalid, go to its GRANT state; if both, go to the source != last_grant; update last_grant on entry. No beats are accepted in IDLE (one bubble cycle per packet).
- Output register: load_ok = !axis_m_tvalid || axis_m_tready.
- GRANT_x: s_tready_x = load_ok, other source's tready=0. On a handshake, copy data/tlast to the output register, set tuser=x, set m_tvalid=1, and beat_cnt++. m_tvalid clears when axis_m_tready=1 and there is no new load. Latency from input to output is 1 cycle.
- GRANT_x on an accepted beat with tlast=1: go to IDLE, beat_cnt=0.
- GRANT_x on an accepted beat with tlast=0 and beat_cnt+1==MAX_BEATS: output tlast forced to 1, err_overflow<=1, beat_cnt=0, go to DRAIN_x.
- DRAIN_x: s_tready_x=1 unconditionally. Accepted beats are discarded and never reach the output. Go to IDLE on an accepted tlast.
- A downstream stall (axis_m_tready=0) holds tdata/tlast/tuser stable and valid. AXIS rule: once valid, output fields must not change until the handshake.
- err_clr together with a new overflow in the same cycle: set wins.
- Reset mid-packet: output valid drops immediately and the partial packet is lost. After release, arbitration restarts with the even source preferred.
- tvalid on a non-granted source is ignored; it may stay high indefinitely.

Optional Feature:
Macro PARITY_ARB_STATS_EN.
- Defined: adds outputs pkt_cnt_even[15:0], pkt_cnt_odd[15:0] and drop_cnt[15:0], all reset to 0.
  - pkt_cnt_x increments on each output beat with tlast whose tuser==x.
  - drop_cnt increments on each beat discarded in DRAIN.
  - All counters wrap at 16'hFFFF -> 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Even-only packet A0,A1,A2 (tlast on A2), m_tready=1 -> output A0,A1,A2, tuser=0, tlast only on A2, first beat 2 cycles after the first valid; state returns to IDLE.
- Both sources continuously valid, 2-beat packets each -> output packet order even, odd, even, odd; no interleaving of beats inside a packet.
- Even packet of 4 beats with m_tready toggled 1,0,0,1,... -> every beat delivered once, in order; tdata held stable while m_tready=0.
- Odd packet of 10 beats, MAX_BEATS=8 -> 8 beats output with tlast on beat 8, err_overflow=1, beats 9-10 consumed and dropped; err_clr pulse -> err_overflow=0.
- axis_aresetn low during beat 2 of a 5-beat packet -> m_tvalid=0 asynchronously; after release, a new even packet is arbitrated first and delivered correctly.
- With PARITY_ARB_STATS_EN: 3 even packets, 2 odd packets, 1 overflow packet of 10 beats -> pkt_cnt_even=3, pkt_cnt_odd=3, drop_cnt=2.
